led_sequencer: RTL and testbench

Multi-channel LED controller that owns the design's indicator outputs (power, floppy, HDD, user LEDs) and sequences them. Each channel holds a per-channel mode (off, on, blink, activity) written through a small config port. Activity channels stretch short strobes into visible pulses and force a gap between back-to-back pulses. All timing derives from one shared prescaled tick, and every output is registered.

---
 rtl/led_sequencer_pkg.sv | 23 ++
 rtl/led_act_chan.sv | 123 ++++++++++++
 rtl/led_sequencer.sv | 103 ++++++++++
 tb/tb_led_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer.
// Holds the per-channel mode encodings, the activity FSM state encodings
// and a small helper that maps an "LED lit" request onto the drive level.
// No ports; imported by led_act_chan and led_sequencer.
package led_sequencer_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'b00;
  localparam mode_t MODE_ON    = 2'b01;
  localparam mode_t MODE_BLINK = 2'b10;
  localparam mode_t MODE_ACT   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Outputs idle at ds and light up at the opposite level.
  function automatic logic drive_level(input logic lit, input logic ds);
    return lit ? ~ds : ds;
  endfunction

endpackage

// File: rtl/led_act_chan.sv
// One LED channel: activity pulse stretcher FSM plus the registered output.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   tick_i         shared prescaled tick (one clk wide)
//   phase_i        shared blink phase
//   mode_i         this channel's current mode
//   clr_i          mode write to this channel this cycle (forces IDLE)
//   act_i          activity strobe
//   led_o          registered LED drive
module led_act_chan
  import led_sequencer_pkg::*;
#(
  parameter logic        DS      = 1'b0,
  parameter int unsigned STRETCH = 50,
  parameter int unsigned GAP     = 25
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  tick_i,
  input  logic  phase_i,
  input  mode_t mode_i,
  input  logic  clr_i,
  input  logic  act_i,
  output logic  led_o
);

  localparam int unsigned CMAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int unsigned CW   = $clog2(CMAX);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          led_q, led_d;

  // A mode write wins over everything, including an act in the same cycle.
  // Outside activity mode the FSM is parked in IDLE. In HOLD, an act seen on
  // the expiring tick still counts as a retrigger, which is what turns
  // continuous activity into on/off flicker instead of a solid LED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (clr_i || (mode_i != MODE_ACT)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (act_i) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
            pend_d  = 1'b0;
          end
        end
        ST_HOLD: begin
          pend_d = pend_q | act_i;
          if (tick_i) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (pend_q | act_i) begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
              pend_d  = 1'b0;
            end
          end
        end
        ST_GAP: begin
          pend_d = pend_q | act_i;
          if (tick_i) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = HOLD_LOAD;
              pend_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // Output is computed from registered state only, so every input reaches
  // the pin one edge after it changes the channel state.
  always_comb begin
    led_d = DS;
    case (mode_i)
      MODE_OFF:   led_d = DS;
      MODE_ON:    led_d = ~DS;
      MODE_BLINK: led_d = drive_level(phase_i, DS);
      MODE_ACT:   led_d = drive_level(state_q == ST_HOLD, DS);
      default:    led_d = DS;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      led_q   <= DS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer top.
// Owns the shared prescaler (tick), the shared blink phase generator, the
// per-channel mode registers and one led_act_chan per channel.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   cfg_we_i       config write strobe
//   cfg_adr_i      channel index; indices >= OW match no channel
//   cfg_dat_i      mode: 00 off, 01 on, 10 blink, 11 activity
//   act_i          per-channel activity strobes
//   led_o          registered LED drives
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned OW         = 4,
  parameter logic        DS         = 1'b0,
  parameter int unsigned PRE        = 28000,
  parameter int unsigned BLINK_HALF = 250,
  parameter int unsigned STRETCH    = 50,
  parameter int unsigned GAP        = 25
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_we_i,
  input  logic [3:0]    cfg_adr_i,
  input  logic [1:0]    cfg_dat_i,
  input  logic [OW-1:0] act_i,
  output logic [OW-1:0] led_o
);

  localparam int unsigned PW = $clog2(PRE);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic          tick;

  // Tick is decoded from the registered prescaler value, so it is a clean
  // one-cycle pulse. The blink phase flips each time its counter wraps,
  // and every blinking channel reads the same phase.
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    blk_d   = blk_q;
    phase_d = phase_q;
    if (tick) begin
      if (blk_q == BLINK_LAST) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
    end
  end

  for (genvar i = 0; i < OW; i++) begin : g_chan
    logic  clr;
    mode_t mode_q, mode_d;

    // Full 4-bit address compare: an out-of-range index hits no channel.
    assign clr    = cfg_we_i && (cfg_adr_i == 4'(i));
    assign mode_d = clr ? cfg_dat_i : mode_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mode_q <= MODE_OFF;
      end else begin
        mode_q <= mode_d;
      end
    end

    led_act_chan #(
      .DS     (DS),
      .STRETCH(STRETCH),
      .GAP    (GAP)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_i (tick),
      .phase_i(phase_q),
      .mode_i (mode_q),
      .clr_i  (clr),
      .act_i  (act_i[i]),
      .led_o  (led_o[i])
    );
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer with OW=4, DS=0, PRE=4,
// BLINK_HALF=2, STRETCH=3, GAP=2.
// cyc counts rising edges since the last reset release; every check and
// every input change happens on the falling edge after edge number cyc.
// With PRE=4 the tick is consumed at edges 4, 8, 12, ... and the blink
// phase flips at edges 8, 16, 24, ...
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_adr;
  logic [1:0] cfg_dat;
  logic [3:0] act;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .OW(4), .DS(1'b0), .PRE(4), .BLINK_HALF(2), .STRETCH(3), .GAP(2)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .cfg_we_i (cfg_we),
    .cfg_adr_i(cfg_adr),
    .cfg_dat_i(cfg_dat),
    .act_i    (act),
    .led_o    (led)
  );

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: led=%b expected=%b (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] adr, input logic [1:0] dat,
                               input logic [3:0] a);
    cfg_we  = we;
    cfg_adr = adr;
    cfg_dat = dat;
    act     = a;
  endtask

  task automatic waitTo(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 2'b00, 4'hF);
    repeat (2) @(negedge clk);
    checkOutput("reset_hold_a", led, 4'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_hold_b", led, 4'h0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    cyc = 0;

    // Mode on/off and out-of-range address
    waitTo(2);  checkOutput("after_release", led, 4'h0);
    applyStimulus(1'b1, 4'd1, 2'b01, 4'h0);
    waitTo(3);  checkOutput("on_lag", led, 4'h0);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(4);  checkOutput("ch1_on", led, 4'b0010);
    applyStimulus(1'b1, 4'd1, 2'b00, 4'h0);
    waitTo(5);  checkOutput("off_lag", led, 4'b0010);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(6);  checkOutput("ch1_off", led, 4'h0);
    applyStimulus(1'b1, 4'd5, 2'b01, 4'h0);
    waitTo(7);  applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(8);  checkOutput("adr5_ignored", led, 4'h0);

    // Blink: phase is 1 after edge 8, 0 after 16, 1 after 24, 0 after 32
    applyStimulus(1'b1, 4'd0, 2'b10, 4'h0);
    waitTo(9);  checkOutput("blink_lag", led, 4'h0);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(10); checkOutput("blink_hi", led, 4'b0001);
    waitTo(16); checkOutput("blink_hi_end", led, 4'b0001);
    waitTo(17); checkOutput("blink_lo", led, 4'b0000);
    waitTo(18); applyStimulus(1'b1, 4'd2, 2'b10, 4'h0);
    waitTo(19); applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(24); checkOutput("blink2_lo", led, 4'b0000);
    waitTo(25); checkOutput("blink2_hi", led, 4'b0101);
    waitTo(32); checkOutput("blink2_hi_end", led, 4'b0101);
    waitTo(33); checkOutput("blink2_lo2", led, 4'b0000);
    applyStimulus(1'b1, 4'd0, 2'b00, 4'h0);
    waitTo(34); applyStimulus(1'b1, 4'd2, 2'b00, 4'h0);
    waitTo(35); applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(36); checkOutput("blink_off", led, 4'h0);

    // Activity single pulse: HOLD at edge 38, ticks at 40, 44, 48 -> IDLE
    applyStimulus(1'b1, 4'd3, 2'b11, 4'h0);
    waitTo(37); applyStimulus(1'b0, 4'd0, 2'b00, 4'h8);
    waitTo(38); checkOutput("act_lag", led, 4'h0);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(39); checkOutput("act_on", led, 4'h8);
    waitTo(48); checkOutput("act_on_end", led, 4'h8);
    waitTo(49); checkOutput("act_off", led, 4'h0);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h8);
    waitTo(50); applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(51); checkOutput("act_nogap_on", led, 4'h8);
    waitTo(60); checkOutput("act_nogap_end", led, 4'h8);
    waitTo(61); checkOutput("act_nogap_off", led, 4'h0);

    // Retrigger: act held from edge 62 through edge 121
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h8);
    waitTo(62);  checkOutput("rt_lag", led, 4'h0);
    waitTo(63);  checkOutput("rt_on1", led, 4'h8);
    waitTo(72);  checkOutput("rt_on1_end", led, 4'h8);
    waitTo(73);  checkOutput("rt_gap1", led, 4'h0);
    waitTo(80);  checkOutput("rt_gap1_end", led, 4'h0);
    waitTo(81);  checkOutput("rt_on2", led, 4'h8);
    waitTo(92);  checkOutput("rt_on2_end", led, 4'h8);
    waitTo(93);  checkOutput("rt_gap2", led, 4'h0);
    waitTo(100); checkOutput("rt_gap2_end", led, 4'h0);
    waitTo(101); checkOutput("rt_on3", led, 4'h8);
    waitTo(113); checkOutput("rt_gap3", led, 4'h0);
    waitTo(120); checkOutput("rt_gap3_end", led, 4'h0);
    waitTo(121); checkOutput("rt_on4", led, 4'h8);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(132); checkOutput("rt_on4_end", led, 4'h8);
    waitTo(133); checkOutput("rt_gap4", led, 4'h0);
    waitTo(140); checkOutput("rt_gap4_end", led, 4'h0);
    waitTo(141); checkOutput("rt_last_on", led, 4'h8);
    waitTo(152); checkOutput("rt_last_end", led, 4'h8);
    waitTo(153); checkOutput("rt_idle", led, 4'h0);
    waitTo(165); checkOutput("rt_idle_stays", led, 4'h0);

    // Config write with simultaneous act while in HOLD
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h8);
    waitTo(166); applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(168); checkOutput("sim_hold", led, 4'h8);
    applyStimulus(1'b1, 4'd3, 2'b11, 4'h8);
    waitTo(169); checkOutput("sim_lag", led, 4'h8);
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(170); checkOutput("sim_cleared", led, 4'h0);
    waitTo(172); checkOutput("sim_act_ignored", led, 4'h0);

    // Asynchronous reset in the middle of HOLD
    applyStimulus(1'b0, 4'd0, 2'b00, 4'h8);
    waitTo(173); applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(174); checkOutput("pre_areset_hold", led, 4'h8);
    #2 rst_n = 1'b0;
    #1 checkOutput("areset_immediate", led, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    applyStimulus(1'b0, 4'd0, 2'b00, 4'hF);
    waitTo(1); applyStimulus(1'b0, 4'd0, 2'b00, 4'h0);
    waitTo(2); checkOutput("post_reset_modes_off_a", led, 4'h0);
    waitTo(6); checkOutput("post_reset_modes_off_b", led, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
